spi_slave_burst_wr: RTL and testbench

Parametrised SPI slave write port for the SoC pad interface and successor to the single-word SPI receiver. Each frame carries an address header followed by up to MAX_BURST data words. Every complete word is committed as an (address, data) pair, and the address auto-increments between words. Commits are signalled by a toggle for clean CDC into the system clock domain, and per-frame status is latched when SS rises.

---
 rtl/spi_slave_burst_wr.sv | 124 ++++++++++++
 tb/tb_spi_slave_burst_wr.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_burst_wr.sv
// rtl/spi_slave_burst_wr.sv - SPI slave burst write port: address header plus auto-incrementing data words
// Commits raise wr_toggle for CDC; per-frame status is latched on the SS rising edge.
module spi_slave_burst_wr #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int MAX_BURST  = 16,
   parameter int MSB_FIRST  = 1
) (
   input  logic                             SCLK,
   input  logic                             reset,
   input  logic                             SS,
   input  logic                             MOSI,
   output logic [ADDR_WIDTH-1:0]            wr_addr,
   output logic [DATA_WIDTH-1:0]            wr_data,
   output logic                             wr_toggle,
   output logic                             busy,
   output logic [$clog2(MAX_BURST+1)-1:0]   frame_words,
   output logic                             frame_err,
   output logic                             frame_ovf
);

   localparam int SW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CW = $clog2(SW + 1);
   localparam int FW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] HDR_LAST   = CW'(ADDR_WIDTH - 1);
   localparam logic [CW-1:0] WORD_LAST  = CW'(DATA_WIDTH - 1);
   localparam logic [FW-1:0] BURST_LAST = FW'(MAX_BURST - 1);

   typedef enum logic [1:0] {IDLE, HDR, DATA, DROP} state_t;

   state_t                 state;
   logic [CW-1:0]          bit_cnt;
   logic [FW-1:0]          word_cnt;
   logic [SW-1:0]          sh;
   logic [SW-1:0]          sh_d;
   logic [ADDR_WIDTH-1:0]  addr_ptr;
   logic [ADDR_WIDTH-1:0]  hdr_lsb;
   logic [DATA_WIDTH-1:0]  word_lsb;
   logic                   ovf_flag;
   logic                   hdr_done;

   // LSB-first fields shift right within their own width so the first bit ends in bit 0
   always_comb begin
      hdr_lsb = sh[ADDR_WIDTH-1:0] >> 1;
      hdr_lsb[ADDR_WIDTH-1] = MOSI;
      word_lsb = sh[DATA_WIDTH-1:0] >> 1;
      word_lsb[DATA_WIDTH-1] = MOSI;
      sh_d = '0;
      if (MSB_FIRST != 0)
         sh_d = {sh[SW-2:0], MOSI};
      else if (state == DATA)
         sh_d[DATA_WIDTH-1:0] = word_lsb;
      else
         sh_d[ADDR_WIDTH-1:0] = hdr_lsb;
      hdr_done = (state == IDLE) ? (ADDR_WIDTH == 1) : (bit_cnt == HDR_LAST);
   end

   always_ff @(posedge SCLK or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         word_cnt  <= '0;
         sh        <= '0;
         addr_ptr  <= '0;
         ovf_flag  <= 1'b0;
         busy      <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         wr_toggle <= 1'b0;
      end else if (SS) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         word_cnt <= '0;
         sh       <= '0;
         ovf_flag <= 1'b0;
         busy     <= 1'b0;
      end else begin
         busy <= 1'b1;
         case (state)
            IDLE, HDR: begin
               sh <= sh_d;
               if (hdr_done) begin
                  addr_ptr <= sh_d[ADDR_WIDTH-1:0];
                  bit_cnt  <= '0;
                  state    <= DATA;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                  state   <= HDR;
               end
            end
            DATA: begin
               sh <= sh_d;
               if (bit_cnt == WORD_LAST) begin
                  wr_data   <= sh_d[DATA_WIDTH-1:0];
                  wr_addr   <= addr_ptr;
                  wr_toggle <= ~wr_toggle;
                  addr_ptr  <= addr_ptr + 1'b1;
                  word_cnt  <= word_cnt + 1'b1;
                  bit_cnt   <= '0;
                  if (word_cnt == BURST_LAST)
                     state <= DROP;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: ovf_flag <= 1'b1;
         endcase
      end
   end

   // Counters are still intact at the SS edge; they clear on the next SCLK edge with SS high
   always_ff @(posedge SS or negedge reset) begin
      if (!reset) begin
         frame_words <= '0;
         frame_err   <= 1'b0;
         frame_ovf   <= 1'b0;
      end else begin
         frame_words <= word_cnt;
         frame_ovf   <= ovf_flag;
         frame_err   <= (state == HDR) || ((state == DATA) && (bit_cnt != '0));
      end
   end

endmodule

// File: tb/tb_spi_slave_burst_wr.sv
// tb/tb_spi_slave_burst_wr.sv - directed self-checking bench for spi_slave_burst_wr
// Two instances share SCLK/SS/MOSI: one MSB-first, one LSB-first.
module tb_spi_slave_burst_wr;

   logic        SCLK = 1'b0;
   logic        reset = 1'b0;
   logic        SS = 1'b1;
   logic        MOSI = 1'b0;

   logic [7:0]  m_addr, l_addr;
   logic [31:0] m_data, l_data;
   logic        m_tog, l_tog, m_busy, l_busy;
   logic [2:0]  m_words, l_words;
   logic        m_err, l_err, m_ovf, l_ovf;

   int checks = 0;
   int failures = 0;
   logic exp_tog;

   always #5 SCLK = ~SCLK;

   spi_slave_burst_wr #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MAX_BURST(4), .MSB_FIRST(1)) u_msb (
      .SCLK(SCLK), .reset(reset), .SS(SS), .MOSI(MOSI),
      .wr_addr(m_addr), .wr_data(m_data), .wr_toggle(m_tog), .busy(m_busy),
      .frame_words(m_words), .frame_err(m_err), .frame_ovf(m_ovf));

   spi_slave_burst_wr #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MAX_BURST(4), .MSB_FIRST(0)) u_lsb (
      .SCLK(SCLK), .reset(reset), .SS(SS), .MOSI(MOSI),
      .wr_addr(l_addr), .wr_data(l_data), .wr_toggle(l_tog), .busy(l_busy),
      .frame_words(l_words), .frame_err(l_err), .frame_ovf(l_ovf));

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic b);
      @(negedge SCLK);
      SS = 1'b0;
      MOSI = b;
      @(posedge SCLK);
      #1;
   endtask

   task automatic send_bits(input logic [63:0] v, input int n, input bit msb);
      for (int i = 0; i < n; i++)
         drive(msb ? v[n-1-i] : v[i]);
   endtask

   task automatic end_frame();
      @(negedge SCLK);
      SS = 1'b1;
      #1;
   endtask

   task automatic idle_edge();
      @(posedge SCLK);
      #1;
   endtask

   logic [31:0] ovf_words [6];

   initial begin
      for (int i = 0; i < 6; i++) ovf_words[i] = 32'hC0DE_0000 | 32'(i + 1);

      #1;
      check("rst_addr", m_addr, 0);
      check("rst_data", m_data, 0);
      check("rst_tog", m_tog, 0);
      check("rst_busy", m_busy, 0);
      check("rst_words", m_words, 0);
      check("rst_err", m_err, 0);
      check("rst_ovf", m_ovf, 0);
      @(negedge SCLK);
      reset = 1'b1;
      idle_edge();
      idle_edge();
      exp_tog = 1'b0;

      // single word; commit must land exactly on posedge 40
      drive(1'b0);
      check("s_busy_rise", m_busy, 1);
      send_bits(64'h10, 7, 1);
      send_bits(64'hDEADBEEF >> 1, 31, 1);
      check("s_no_commit_39", m_tog, 0);
      drive(1'b1);
      exp_tog = ~exp_tog;
      check("s_addr", m_addr, 8'h10);
      check("s_data", m_data, 32'hDEADBEEF);
      check("s_tog", m_tog, exp_tog);
      end_frame();
      check("s_busy_at_ss", m_busy, 1);
      check("s_words", m_words, 1);
      check("s_err", m_err, 0);
      check("s_ovf", m_ovf, 0);
      idle_edge();
      check("s_busy_fall", m_busy, 0);

      // address wrap FE, FF, 00
      send_bits(64'hFE, 8, 1);
      send_bits(64'h11111111, 32, 1);
      exp_tog = ~exp_tog;
      check("w0_addr", m_addr, 8'hFE);
      check("w0_data", m_data, 32'h11111111);
      check("w0_tog", m_tog, exp_tog);
      send_bits(64'h22222222, 32, 1);
      exp_tog = ~exp_tog;
      check("w1_addr", m_addr, 8'hFF);
      check("w1_data", m_data, 32'h22222222);
      check("w1_tog", m_tog, exp_tog);
      send_bits(64'h33333333, 32, 1);
      exp_tog = ~exp_tog;
      check("w2_addr", m_addr, 8'h00);
      check("w2_data", m_data, 32'h33333333);
      check("w2_tog", m_tog, exp_tog);
      end_frame();
      check("w_words", m_words, 3);
      check("w_ovf", m_ovf, 0);
      idle_edge();

      // overflow: six words, only four committed
      send_bits(64'h00, 8, 1);
      for (int i = 0; i < 6; i++) begin
         send_bits({32'h0, ovf_words[i]}, 32, 1);
         if (i < 4) exp_tog = ~exp_tog;
         check("o_addr", m_addr, (i < 4) ? i : 3);
         check("o_data", m_data, ovf_words[(i < 4) ? i : 3]);
         check("o_tog", m_tog, exp_tog);
      end
      end_frame();
      check("o_ovf", m_ovf, 1);
      check("o_words", m_words, 4);
      check("o_err", m_err, 0);
      idle_edge();

      // partial word, then a clean frame clears err
      send_bits(64'h20, 8, 1);
      send_bits(64'hABCDE, 20, 1);
      check("p_tog", m_tog, exp_tog);
      end_frame();
      check("p_err", m_err, 1);
      check("p_words", m_words, 0);
      check("p_ovf", m_ovf, 0);
      idle_edge();
      send_bits(64'h30, 8, 1);
      send_bits(64'h12345678, 32, 1);
      exp_tog = ~exp_tog;
      check("p2_addr", m_addr, 8'h30);
      check("p2_data", m_data, 32'h12345678);
      end_frame();
      check("p2_err", m_err, 0);
      check("p2_words", m_words, 1);
      idle_edge();

      // LSB-first frame; the MSB-first instance sees the bit-reversed values
      send_bits(64'h80, 8, 0);
      send_bits(64'h1, 32, 0);
      exp_tog = ~exp_tog;
      check("l_addr", l_addr, 8'h80);
      check("l_data", l_data, 32'h00000001);
      check("l_mref_addr", m_addr, 8'h01);
      check("l_mref_data", m_data, 32'h80000000);
      check("l_mref_tog", m_tog, exp_tog);
      end_frame();
      check("l_words", l_words, 1);
      check("l_err", l_err, 0);
      idle_edge();

      // reset mid-frame clears everything without a clock edge
      send_bits(64'h40, 8, 1);
      send_bits(64'hFFFFF, 20, 1);
      @(negedge SCLK);
      reset = 1'b0;
      #1;
      check("r_addr", m_addr, 0);
      check("r_data", m_data, 0);
      check("r_tog", m_tog, 0);
      check("r_busy", m_busy, 0);
      check("r_words", m_words, 0);
      check("r_err", m_err, 0);
      check("r_ovf", m_ovf, 0);
      SS = 1'b1;
      @(negedge SCLK);
      reset = 1'b1;
      idle_edge();
      send_bits(64'h05, 8, 1);
      send_bits(64'hA5A5A5A5, 32, 1);
      check("r2_addr", m_addr, 8'h05);
      check("r2_data", m_data, 32'hA5A5A5A5);
      check("r2_tog", m_tog, 1);
      end_frame();
      check("r2_words", m_words, 1);
      check("r2_err", m_err, 0);
      idle_edge();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
